// File: rtl/credit_transmitter_pkg.sv
// Shared types and constants for the credit transmitter and its counter.
// The default credit-count type matches CREDITS=4; the top derives its own width from CREDITS.
package credit_transmitter_pkg;

   localparam int CREDITS_DEFAULT       = 4;
   localparam int CREDITS_WIDTH_DEFAULT = $clog2(CREDITS_DEFAULT + 1);

   typedef logic [CREDITS_WIDTH_DEFAULT-1:0] credit_count_t;

   localparam logic OVERFLOW_ERROR_RESET = 1'b0;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a synchronous reset to RESET_VALUE.
// Latency 1 cycle (count is registered); simultaneous increment and decrement hold the count.
module credit_counter
   import credit_transmitter_pkg::*;
#(
   parameter int WIDTH       = CREDITS_WIDTH_DEFAULT,
   parameter int MAX_VALUE   = CREDITS_DEFAULT,
   parameter int RESET_VALUE = CREDITS_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             increment,
   input  logic             decrement,
   output logic [WIDTH-1:0] count,
   output logic             is_zero,
   output logic             is_max
);

   assign is_zero = (count == '0);
   assign is_max  = (count == WIDTH'(MAX_VALUE));

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= WIDTH'(RESET_VALUE);
      end else if (increment && !decrement && !is_max) begin
         count <= count + WIDTH'(1);
      end else if (decrement && !increment && !is_zero) begin
         count <= count - WIDTH'(1);
      end
   end

endmodule

// File: rtl/credit_transmitter.sv
// Credit-based link transmitter; optional sticky overflow_error port under CREDIT_TRANSMITTER_ERROR_EN.
// Latency 1 cycle upstream->link; upstream_ready drops when no credits remain, the link never backpressures.
module credit_transmitter
   import credit_transmitter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int CREDITS = CREDITS_DEFAULT,
   localparam int CREDITS_WIDTH = $clog2(CREDITS + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     upstream_valid,
   input  logic [WIDTH-1:0]         upstream_data,
   output logic                     upstream_ready,
   output logic                     downstream_valid,
   output logic [WIDTH-1:0]         downstream_data,
   input  logic                     credit_return,
   output logic [CREDITS_WIDTH-1:0] credits
`ifdef CREDIT_TRANSMITTER_ERROR_EN
   ,
   output logic                     overflow_error
`endif
);

   logic transfer;
   logic no_credits;
   logic full;
   logic return_at_full;

   assign upstream_ready = !no_credits;
   assign transfer       = upstream_valid && upstream_ready;

   // A return with nothing outstanding is a receiver bug; it is dropped so the count cannot exceed CREDITS.
   assign return_at_full = credit_return && full && !transfer;

   credit_counter #(
      .WIDTH       (CREDITS_WIDTH),
      .MAX_VALUE   (CREDITS),
      .RESET_VALUE (CREDITS)
   ) u_credit_counter (
      .clock     (clock),
      .reset     (reset),
      .increment (credit_return && !return_at_full),
      .decrement (transfer),
      .count     (credits),
      .is_zero   (no_credits),
      .is_max    (full)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         downstream_valid <= 1'b0;
         downstream_data  <= '0;
      end else begin
         downstream_valid <= transfer;
         if (transfer) begin
            downstream_data <= upstream_data;
         end
      end
   end

`ifdef CREDIT_TRANSMITTER_ERROR_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_error <= OVERFLOW_ERROR_RESET;
      end else if (return_at_full) begin
         overflow_error <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_credit_transmitter.sv
// Bench for credit_transmitter (WIDTH=8, CREDITS=4): directed scenarios plus random traffic vs. a credit-count model.
module tb_credit_transmitter;

   localparam int WIDTH   = 8;
   localparam int CREDITS = 4;
   localparam int CW      = $clog2(CREDITS + 1);

   logic             clock;
   logic             reset;
   logic             upstream_valid;
   logic [WIDTH-1:0] upstream_data;
   logic             upstream_ready;
   logic             downstream_valid;
   logic [WIDTH-1:0] downstream_data;
   logic             credit_return;
   logic [CW-1:0]    credits;
`ifdef CREDIT_TRANSMITTER_ERROR_EN
   logic             overflow_error;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: what the link should show after the latest edge.
   int               m_credits;
   logic             m_vld;
   logic [WIDTH-1:0] m_data;
   logic             m_ovf;

   credit_transmitter #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
      .clock            (clock),
      .reset            (reset),
      .upstream_valid   (upstream_valid),
      .upstream_data    (upstream_data),
      .upstream_ready   (upstream_ready),
      .downstream_valid (downstream_valid),
      .downstream_data  (downstream_data),
      .credit_return    (credit_return),
      .credits          (credits)
`ifdef CREDIT_TRANSMITTER_ERROR_EN
      ,
      .overflow_error   (overflow_error)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of inputs, advance the model across the rising edge, return at the falling edge.
   task automatic tick(input logic rst, input logic v, input logic [WIDTH-1:0] d, input logic r);
      bit sent;
      reset          = rst;
      upstream_valid = v;
      upstream_data  = d;
      credit_return  = r;
      @(posedge clock);
      if (rst) begin
         m_credits = CREDITS;
         m_vld     = 1'b0;
         m_data    = '0;
         m_ovf     = 1'b0;
      end else begin
         sent = v && (m_credits > 0);
         if (r && !sent && m_credits == CREDITS) m_ovf = 1'b1;
         m_credits = m_credits - int'(sent) + int'(r);
         if (m_credits > CREDITS) m_credits = CREDITS;
         m_vld = sent;
         if (sent) m_data = d;
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b1, 8'hA5, 1'b1);
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      checks += 4;
      if (credits !== CW'(4)) begin errors++; $display("FAIL reset_credits: got %0d want 4", credits); end
      if (upstream_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", upstream_ready); end
      if (downstream_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", downstream_valid); end
      if (downstream_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", downstream_data); end
`ifdef CREDIT_TRANSMITTER_ERROR_EN
      checks++;
      if (overflow_error !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow_error); end
`endif
   endtask

   task automatic test_fill();
      logic [WIDTH-1:0] d;
      for (int i = 0; i < 5; i++) begin
         d = WIDTH'(8'h11 * (i + 1));
         tick(1'b0, 1'b1, d, 1'b0);
         checks += 3;
         if (credits !== CW'(m_credits)) begin errors++; $display("FAIL fill_credits[%0d]: got %0d want %0d", i, credits, m_credits); end
         if (downstream_valid !== m_vld) begin errors++; $display("FAIL fill_valid[%0d]: got %b want %b", i, downstream_valid, m_vld); end
         if (downstream_data !== m_data) begin errors++; $display("FAIL fill_data[%0d]: got %h want %h", i, downstream_data, m_data); end
      end
      checks += 3;
      if (upstream_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_low: got %b want 0", upstream_ready); end
      if (downstream_data !== 8'h44) begin errors++; $display("FAIL fill_last_word: got %h want 44", downstream_data); end
      if (credits !== CW'(0)) begin errors++; $display("FAIL fill_empty: got %0d want 0", credits); end
   endtask

   task automatic test_return_one();
      tick(1'b0, 1'b1, 8'h55, 1'b1);
      checks += 2;
      if (credits !== CW'(1)) begin errors++; $display("FAIL ret1_credits: got %0d want 1", credits); end
      if (downstream_valid !== 1'b0) begin errors++; $display("FAIL ret1_no_send: got %b want 0", downstream_valid); end
      tick(1'b0, 1'b1, 8'h55, 1'b0);
      checks += 3;
      if (downstream_valid !== 1'b1) begin errors++; $display("FAIL ret1_valid: got %b want 1", downstream_valid); end
      if (downstream_data !== 8'h55) begin errors++; $display("FAIL ret1_data: got %h want 55", downstream_data); end
      if (credits !== CW'(0)) begin errors++; $display("FAIL ret1_back_to_zero: got %0d want 0", credits); end
   endtask

   task automatic test_send_and_return();
      logic [WIDTH-1:0] d;
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) begin
         d = WIDTH'($urandom);
         tick(1'b0, 1'b1, d, 1'b1);
         checks += 3;
         if (credits !== CW'(2)) begin errors++; $display("FAIL sr_credits[%0d]: got %0d want 2", i, credits); end
         if (downstream_valid !== 1'b1) begin errors++; $display("FAIL sr_valid[%0d]: got %b want 1", i, downstream_valid); end
         if (downstream_data !== d) begin errors++; $display("FAIL sr_data[%0d]: got %h want %h", i, downstream_data, d); end
      end
   endtask

   task automatic test_return_at_full();
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0, 8'h00, 1'b1);
         checks++;
         if (credits !== CW'(4)) begin errors++; $display("FAIL full_saturate[%0d]: got %0d want 4", i, credits); end
`ifdef CREDIT_TRANSMITTER_ERROR_EN
         checks++;
         if (overflow_error !== 1'b1) begin errors++; $display("FAIL full_ovf[%0d]: got %b want 1", i, overflow_error); end
`endif
      end
      tick(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef CREDIT_TRANSMITTER_ERROR_EN
      checks++;
      if (overflow_error !== 1'b1) begin errors++; $display("FAIL full_ovf_sticky: got %b want 1", overflow_error); end
`endif
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, WIDTH'(8'hC0 + i), 1'b0);
      checks++;
      if (credits !== CW'(1)) begin errors++; $display("FAIL mid_pre_credits: got %0d want 1", credits); end
      tick(1'b1, 1'b1, 8'hEE, 1'b0);
      checks += 2;
      if (credits !== CW'(4)) begin errors++; $display("FAIL mid_credits: got %0d want 4", credits); end
      if (downstream_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", downstream_valid); end
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (downstream_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped: got %b want 0", downstream_valid); end
`ifdef CREDIT_TRANSMITTER_ERROR_EN
      checks++;
      if (overflow_error !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b want 0", overflow_error); end
`endif
   endtask

   task automatic test_random();
      logic rst, v, r;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         v   = ($urandom_range(0, 9) < 7);
         r   = ($urandom_range(0, 9) < 4);
         checks++;
         if (upstream_ready !== (m_credits != 0)) begin
            errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, upstream_ready, m_credits != 0);
         end
         tick(rst, v, WIDTH'($urandom), r);
         checks += 3;
         if (credits !== CW'(m_credits)) begin errors++; $display("FAIL rnd_credits[%0d]: got %0d want %0d", i, credits, m_credits); end
         if (downstream_valid !== m_vld) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, downstream_valid, m_vld); end
         if (downstream_data !== m_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, downstream_data, m_data); end
`ifdef CREDIT_TRANSMITTER_ERROR_EN
         checks++;
         if (overflow_error !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, overflow_error, m_ovf); end
`endif
      end
   endtask

   initial begin
      reset          = 1'b1;
      upstream_valid = 1'b0;
      upstream_data  = '0;
      credit_return  = 1'b0;
      m_credits      = CREDITS;
      m_vld          = 1'b0;
      m_data         = '0;
      m_ovf          = 1'b0;
      test_reset();
      test_fill();
      test_return_one();
      test_send_and_return();
      test_return_at_full();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
